// File: rtl/basys3_disp_pkg.sv
// Shared constants for the BASYS3 LED / seven-segment output peripheral.
// Register map, CTRL layout, hex glyph table and scan FSM encoding.
package basys3_disp_pkg;

  localparam logic [1:0] ADDR_LED    = 2'd0;
  localparam logic [1:0] ADDR_VALUE  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_W      = 9;
  localparam int CTRL_EN_LSB = 0;
  localparam int CTRL_DP_LSB = 4;
  localparam int CTRL_ON_BIT = 8;

  localparam logic [CTRL_W-1:0] CTRL_RST = 9'h10F;

  // gfedcba, active-low
  localparam logic [6:0] HEX7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/basys3_disp_out_hex7seg_decoder.sv
// Nibble to active-low seven-segment glyph (gfedcba).
// Purely combinational.
module hex7seg_decoder
  import basys3_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX7_LUT[nibble];

endmodule

// File: rtl/basys3_disp_out.sv
// BASYS3 output peripheral: LED register and 4-digit multiplexed display.
// Bus-mapped registers, blank/show scan FSM, registered pin drivers.
module basys3_disp_out
  import basys3_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LED_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [1:0]       address,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic [LED_W-1:0] led,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);

  logic [LED_W-1:0]  led_q, led_d;
  logic [15:0]       value_q, value_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;

  scan_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        digit_q, digit_d;

  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              accept;
  logic              wr;
  logic [31:0]       status_w;
  logic [3:0]        nib;
  logic [6:0]        nib_seg;
  logic [3:0]        dig_en;
  logic [3:0]        dig_dp;
  logic              lit;

  assign accept   = valid & ~ready_q;
  assign wr       = accept & (|wstrb);
  assign status_w = {29'd0, state_q == ST_BLANK, digit_q};

  always_comb begin
    led_d   = led_q;
    value_d = value_q;
    ctrl_d  = ctrl_q;
    ready_d = accept;
    rdata_d = rdata_q;
    if (accept) begin
      unique case (address)
        ADDR_LED:    rdata_d = 32'(led_q);
        ADDR_VALUE:  rdata_d = 32'(value_q);
        ADDR_CTRL:   rdata_d = 32'(ctrl_q);
        ADDR_STATUS: rdata_d = status_w;
      endcase
    end
    if (wr) begin
      unique case (address)
        ADDR_LED:
          led_d = LED_W'(strb_merge(32'(led_q), wdata, wstrb));
        ADDR_VALUE:
          value_d = 16'(strb_merge(32'(value_q), wdata, wstrb));
        ADDR_CTRL:
          ctrl_d = CTRL_W'(strb_merge(32'(ctrl_q), wdata, wstrb));
        ADDR_STATUS: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    digit_d = digit_q;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          digit_d = digit_q + 2'd1;
          state_d = ST_BLANK;
        end
      end
    endcase
  end

  assign dig_en = ctrl_q[CTRL_EN_LSB +: 4];
  assign dig_dp = ctrl_q[CTRL_DP_LSB +: 4];
  assign nib    = value_q[{digit_q, 2'b00} +: 4];
  assign lit    = (state_q == ST_SHOW) & ctrl_q[CTRL_ON_BIT]
                & dig_en[digit_q];

  hex7seg_decoder u_hex (
    .nibble (nib),
    .seg_n  (nib_seg)
  );

  // Pins follow the current state and registers one cycle later.
  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = nib_seg;
      dp_d  = ~dig_dp[digit_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= '0;
      value_q <= '0;
      ctrl_q  <= CTRL_RST;
      ready_q <= 1'b0;
      rdata_q <= '0;
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      digit_q <= '0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      led_q   <= led_d;
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign led   = led_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;

endmodule

// File: tb/tb_basys3_disp_out.sv
// Directed bench for basys3_disp_out: register table, scan timing,
// handshake pattern and asynchronous reset.
module tb_basys3_disp_out;

  localparam int RD = 16;
  localparam int BC = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid = 1'b0;
  logic [1:0]    address = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic [LW-1:0] led;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;

  basys3_disp_out #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .LED_W        (LW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .address (address),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata),
    .ready   (ready),
    .led     (led),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] value_m;
  logic [8:0]  ctrl_m;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic        chk_rd;
    logic [31:0] rd_exp;
    logic [15:0] led_exp;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;
      4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;
      4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;
      4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;
      4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [31:0] status_at(input int k);
    int c;
    int d;
    c = k % RD;
    d = (k / RD) % 4;
    return {29'd0, c < BC, 2'(d)};
  endfunction

  task automatic scan_check(input int ncyc, input string tag);
    logic [11:0] exp;
    int s, c, d;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      exp = {4'hF, 1'b1, 7'h7F};
      if (cyc > 0) begin
        s = cyc - 1;
        c = s % RD;
        d = (s / RD) % 4;
        if (c >= BC && ctrl_m[8] && ctrl_m[d]) begin
          exp[11:8] = ~(4'b0001 << d);
          exp[7]    = ~ctrl_m[4+d];
          exp[6:0]  = hex7(4'((value_m >> (d*4)) & 16'hF));
        end
      end
      check(tag, {20'd0, an, dp, seg}, {20'd0, exp});
    end
  endtask

  task automatic xact(input logic [1:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd,
                      output int k0);
    @(negedge clk);
    k0 = cyc;
    valid = 1'b1;
    address = a;
    wdata = wd;
    wstrb = st;
    check("ready_pre", 32'(ready), 32'd0);
    @(negedge clk);
    check("ready_ack", 32'(ready), 32'd1);
    rd = rdata;
    valid = 1'b0;
    wstrb = '0;
    @(negedge clk);
    check("ready_drop", 32'(ready), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int k0;

    tbl[0]  = '{2'd0, 32'h0000A5A5, 4'hF, 1'b1, 32'h0000_0000, 16'hA5A5};
    tbl[1]  = '{2'd0, 32'h0000FF00, 4'h2, 1'b1, 32'h0000_A5A5, 16'hFFA5};
    tbl[2]  = '{2'd0, 32'h0,        4'h0, 1'b1, 32'h0000_FFA5, 16'hFFA5};
    tbl[3]  = '{2'd1, 32'h00001234, 4'hF, 1'b1, 32'h0000_0000, 16'hFFA5};
    tbl[4]  = '{2'd1, 32'h0,        4'h0, 1'b1, 32'h0000_1234, 16'hFFA5};
    tbl[5]  = '{2'd2, 32'h0,        4'h0, 1'b1, 32'h0000_010F, 16'hFFA5};
    tbl[6]  = '{2'd3, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0000_0000, 16'hFFA5};
    tbl[7]  = '{2'd0, 32'h0,        4'h0, 1'b1, 32'h0000_FFA5, 16'hFFA5};
    tbl[8]  = '{2'd0, 32'hDEADBEEF, 4'h1, 1'b1, 32'h0000_FFA5, 16'hFFEF};
    tbl[9]  = '{2'd1, 32'h00FF0000, 4'h4, 1'b1, 32'h0000_1234, 16'hFFEF};
    tbl[10] = '{2'd1, 32'h0,        4'h0, 1'b1, 32'h0000_1234, 16'hFFEF};
    tbl[11] = '{2'd2, 32'hFFFFFE00, 4'h3, 1'b1, 32'h0000_010F, 16'hFFEF};
    tbl[12] = '{2'd2, 32'h0,        4'h0, 1'b1, 32'h0000_0000, 16'hFFEF};
    tbl[13] = '{2'd2, 32'h0000010F, 4'hF, 1'b1, 32'h0000_0000, 16'hFFEF};
    tbl[14] = '{2'd2, 32'h0,        4'h0, 1'b1, 32'h0000_010F, 16'hFFEF};

    value_m = 16'h0;
    ctrl_m  = 9'h10F;

    #12;
    check("rst_led", 32'(led), 32'd0);
    check("rst_pins", {20'd0, an, dp, seg}, {20'd0, 4'hF, 1'b1, 7'h7F});
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    scan_check(64, "scan_idle");

    for (int i = 0; i < 5; i++) begin
      xact(2'd3, 32'h0, 4'h0, rd, k0);
      check("status_rd", rd, status_at(k0));
      repeat (13) @(negedge clk);
    end

    foreach (tbl[i]) begin
      xact(tbl[i].addr, tbl[i].wd, tbl[i].st, rd, k0);
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd_exp);
      check($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led_exp));
    end
    value_m = 16'h1234;
    ctrl_m  = 9'h10F;
    scan_check(64, "scan_1234");

    xact(2'd2, 32'h00000125, 4'hF, rd, k0);
    ctrl_m = 9'h125;
    scan_check(64, "scan_ctrl125");

    xact(2'd2, 32'h000000FF, 4'hF, rd, k0);
    ctrl_m = 9'h0FF;
    scan_check(64, "scan_off");

    @(negedge clk);
    valid = 1'b1;
    address = 2'd3;
    wstrb = 4'h0;
    check("b2b_0", 32'(ready), 32'd0);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b2b_%0d", i), 32'(ready), 32'(i % 2));
    end
    valid = 1'b0;

    xact(2'd2, 32'h0000010F, 4'hF, rd, k0);
    ctrl_m = 9'h10F;
    for (int i = 0; i < 200 && (cyc % 64) != 40; i++) @(negedge clk);
    check("align_d2", 32'(cyc % 64), 32'd40);
    check("pre_rst_an", 32'(an), 32'hB);
    valid = 1'b1;
    address = 2'd0;
    wdata = 32'h00001234;
    wstrb = 4'hF;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_pins", {20'd0, an, dp, seg}, {20'd0, 4'hF, 1'b1, 7'h7F});
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_led", 32'(led), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    valid = 1'b0;
    wstrb = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    value_m = 16'h0;
    ctrl_m  = 9'h10F;
    scan_check(20, "scan_post_rst");
    xact(2'd0, 32'h0, 4'h0, rd, k0);
    check("post_led", rd, 32'd0);
    xact(2'd1, 32'h0, 4'h0, rd, k0);
    check("post_value", rd, 32'd0);
    xact(2'd2, 32'h0, 4'h0, rd, k0);
    check("post_ctrl", rd, 32'h10F);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
